// File: rtl/video_timing_pattern_gen_pkg.sv
// Shared timing defaults, pattern encoding and bar colours for the
// 640x480 test-pattern source.
package video_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_SYNC_POL = 1'b0;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_CHECKER = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      3'd7:    c = RGB_BLACK;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_timing_pattern_gen_if.sv
// Pattern configuration in, raster timing and pixel colour out.
interface video_timing_pattern_gen_if;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;
  logic [7:0]  frame_count;

  modport master (
    input  pattern_sel, solid_rgb,
    output hsync, vsync, de, red, green, blue, frame_start, frame_count
  );

  modport slave (
    output pattern_sel, solid_rgb,
    input  hsync, vsync, de, red, green, blue, frame_start, frame_count
  );
endinterface

// File: rtl/video_timing_pattern_gen_counter.sv
// Raster position counters with combinational active/sync/frame-origin
// decode of the current position (the top registers everything).
module video_timing_counter
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int HW       = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW       = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
)(
  input  logic          clk_low,
  input  logic          reset,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          line_end,
  output logic          active,
  output logic          hsync_on,
  output logic          vsync_on,
  output logic          frame_origin
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Pixel and line counters; the line counter advances on the pixel wrap.
  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      h_cnt <= {HW{1'b0}};
      v_cnt <= {VW{1'b0}};
    end else if (line_end) begin
      h_cnt <= {HW{1'b0}};
      if (v_cnt == V_LAST) begin
        v_cnt <= {VW{1'b0}};
      end else begin
        v_cnt <= v_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Position decode; vsync depends on v_cnt only so it spans whole lines.
  always_comb begin
    line_end     = (h_cnt == H_LAST);
    active       = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hsync_on     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vsync_on     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    frame_origin = (h_cnt == {HW{1'b0}}) && (v_cnt == {VW{1'b0}});
  end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// 640x480 raster generator with frame-latched test-pattern selection;
// every output is registered one cycle after the position it describes.
module video_timing_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL
)(
  input logic                        clk_low,
  input logic                        reset,
  video_timing_pattern_gen_if.master vid
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BPW-1:0] BAR_LAST = BPW'(BAR_W - 1);

  logic [HW-1:0]  h_cnt_s;
  logic [VW-1:0]  v_cnt_s;
  logic           line_end_s;
  logic           active_s;
  logic           hsync_on_s;
  logic           vsync_on_s;
  logic           frame_origin_s;
  pattern_e       pat_r;
  pattern_e       pat_s;
  logic [23:0]    solid_r;
  logic [23:0]    solid_s;
  logic           first_frame_r;
  logic [BPW-1:0] bar_pix_r;
  logic [2:0]     bar_idx_r;
  logic [7:0]     ramp_s;
  logic           h_bit5_s;
  logic           v_bit5_s;
  logic [23:0]    rgb_s;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_counter (
    .clk_low      (clk_low),
    .reset        (reset),
    .h_cnt        (h_cnt_s),
    .v_cnt        (v_cnt_s),
    .line_end     (line_end_s),
    .active       (active_s),
    .hsync_on     (hsync_on_s),
    .vsync_on     (vsync_on_s),
    .frame_origin (frame_origin_s)
  );

  // Pixel (0,0) already uses the selection being captured for the new frame.
  assign pat_s    = frame_origin_s ? pattern_e'(vid.pattern_sel) : pat_r;
  assign solid_s  = frame_origin_s ? vid.solid_rgb : solid_r;
  assign ramp_s   = 8'(h_cnt_s >> 2);
  assign h_bit5_s = |(h_cnt_s & HW'(32));
  assign v_bit5_s = |(v_cnt_s & VW'(32));

  // Frame-coherent capture of the pattern selection and solid colour.
  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      pat_r         <= PAT_BARS;
      solid_r       <= 24'h000000;
      first_frame_r <= 1'b1;
    end else if (frame_origin_s) begin
      pat_r         <= pat_s;
      solid_r       <= solid_s;
      first_frame_r <= 1'b0;
    end
  end

  // Bar position tracks h_cnt with a sub-counter instead of a divide.
  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      bar_pix_r <= {BPW{1'b0}};
      bar_idx_r <= 3'd0;
    end else if (line_end_s) begin
      bar_pix_r <= {BPW{1'b0}};
      bar_idx_r <= 3'd0;
    end else if (bar_pix_r == BAR_LAST) begin
      bar_pix_r <= {BPW{1'b0}};
      bar_idx_r <= bar_idx_r + 3'd1;
    end else begin
      bar_pix_r <= bar_pix_r + 1'b1;
    end
  end

  // Colour for the current position; blanking forces black.
  always_comb begin
    rgb_s = RGB_BLACK;
    if (active_s) begin
      case (pat_s)
        PAT_BARS:    rgb_s = bar_colour(bar_idx_r);
        PAT_CHECKER: rgb_s = (h_bit5_s ^ v_bit5_s) ? RGB_BLACK : RGB_WHITE;
        PAT_RAMP:    rgb_s = {ramp_s, ramp_s, ramp_s};
        PAT_SOLID:   rgb_s = solid_s;
        default:     rgb_s = RGB_BLACK;
      endcase
    end else begin
      rgb_s = RGB_BLACK;
    end
  end

  // Output registers keep sync, de and colour mutually aligned.
  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      vid.hsync       <= ~SYNC_POL;
      vid.vsync       <= ~SYNC_POL;
      vid.de          <= 1'b0;
      vid.red         <= 8'h00;
      vid.green       <= 8'h00;
      vid.blue        <= 8'h00;
      vid.frame_start <= 1'b0;
      vid.frame_count <= 8'h00;
    end else begin
      vid.hsync       <= hsync_on_s ? SYNC_POL : ~SYNC_POL;
      vid.vsync       <= vsync_on_s ? SYNC_POL : ~SYNC_POL;
      vid.de          <= active_s;
      vid.red         <= rgb_s[23:16];
      vid.green       <= rgb_s[15:8];
      vid.blue        <= rgb_s[7:0];
      vid.frame_start <= frame_origin_s;
      if (frame_origin_s && !first_frame_r) begin
        vid.frame_count <= vid.frame_count + 8'd1;
      end
    end
  end

endmodule
